// File: rtl/conv_window_addr_gen_if.sv
// Address-tuple bus from the window address generator to the MAC pipeline.
// master = generator side, slave = consumer side (drives addr_ready).
interface conv_window_addr_gen_if #(
    parameter int ADDR_W = 16
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [ADDR_W-1:0] k_addr;
    logic [ADDR_W-1:0] filt_addr;
    logic              win_last;

    modport master (
        output addr_valid, im_addr, k_addr, filt_addr, win_last,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, im_addr, k_addr, filt_addr, win_last,
        output addr_ready
    );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Sliding-window address generator: walks every KER_SIZE x KER_SIZE window of an
// IMG_W x IMG_H image at STRIDE, one image/kernel/output address tuple per tap.
module conv_window_addr_gen #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int KER_SIZE = 3,
    parameter int STRIDE   = 1,
    parameter int ADDR_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    conv_window_addr_gen_if.master        addr_bus,
    output logic                          busy,
    output logic                          done
);
    localparam int OUT_W = (IMG_W - KER_SIZE) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - KER_SIZE) / STRIDE + 1;

    localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(KER_SIZE - 1);
    localparam logic [ADDR_W-1:0] OCOL_LAST  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OROW_LAST  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(STRIDE * IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] kj_reg, kj_next, ki_reg, ki_next;
    logic [ADDR_W-1:0] ocol_reg, ocol_next, orow_reg, orow_next;
    logic [ADDR_W-1:0] row_org_reg, row_org_next;   // address of window row band origin
    logic [ADDR_W-1:0] win_base_reg, win_base_next; // address of window top-left pixel
    logic [ADDR_W-1:0] tap_base_reg, tap_base_next; // address of current kernel row start
    logic [ADDR_W-1:0] im_reg, im_next, k_reg, k_next, filt_reg, filt_next;
    logic              win_last_reg, win_last_next;
    logic              valid_reg, valid_next, busy_reg, busy_next, done_reg, done_next;
    logic              xfer, final_xfer;

    assign xfer       = valid_reg & addr_bus.addr_ready;
    assign final_xfer = xfer & win_last_reg & (ocol_reg == OCOL_LAST) & (orow_reg == OROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start) state_next = S_RUN;
                S_RUN:   if (final_xfer) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are computed for the state being entered so they come out registered.
    always_comb begin
        kj_next       = kj_reg;
        ki_next       = ki_reg;
        ocol_next     = ocol_reg;
        orow_next     = orow_reg;
        row_org_next  = row_org_reg;
        win_base_next = win_base_reg;
        tap_base_next = tap_base_reg;
        im_next       = im_reg;
        k_next        = k_reg;
        filt_next     = filt_reg;
        win_last_next = win_last_reg;
        valid_next    = (state_next == S_RUN);
        busy_next     = (state_next == S_RUN);
        done_next     = (state_next == S_DONE);

        if (state_next != S_RUN || state_reg != S_RUN) begin
            kj_next       = '0;
            ki_next       = '0;
            ocol_next     = '0;
            orow_next     = '0;
            row_org_next  = '0;
            win_base_next = '0;
            tap_base_next = '0;
            im_next       = '0;
            k_next        = '0;
            filt_next     = '0;
            win_last_next = (state_next == S_RUN) && (KER_SIZE == 1);
        end else if (xfer) begin
            if (kj_reg != K_LAST) begin
                kj_next = kj_reg + 1'b1;
                im_next = im_reg + 1'b1;
                k_next  = k_reg + 1'b1;
            end else if (ki_reg != K_LAST) begin
                kj_next       = '0;
                ki_next       = ki_reg + 1'b1;
                tap_base_next = tap_base_reg + ROW_STEP;
                im_next       = tap_base_next;
                k_next        = k_reg + 1'b1;
            end else begin
                // Window wrap: output index is row-major, so it simply counts up.
                kj_next   = '0;
                ki_next   = '0;
                k_next    = '0;
                filt_next = filt_reg + 1'b1;
                if (ocol_reg != OCOL_LAST) begin
                    ocol_next     = ocol_reg + 1'b1;
                    win_base_next = win_base_reg + COL_STRIDE;
                end else begin
                    ocol_next     = '0;
                    orow_next     = orow_reg + 1'b1;
                    row_org_next  = row_org_reg + ROW_STRIDE;
                    win_base_next = row_org_next;
                end
                tap_base_next = win_base_next;
                im_next       = win_base_next;
            end
            win_last_next = (kj_next == K_LAST) && (ki_next == K_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kj_reg       <= '0;
            ki_reg       <= '0;
            ocol_reg     <= '0;
            orow_reg     <= '0;
            row_org_reg  <= '0;
            win_base_reg <= '0;
            tap_base_reg <= '0;
            im_reg       <= '0;
            k_reg        <= '0;
            filt_reg     <= '0;
            win_last_reg <= 1'b0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            kj_reg       <= kj_next;
            ki_reg       <= ki_next;
            ocol_reg     <= ocol_next;
            orow_reg     <= orow_next;
            row_org_reg  <= row_org_next;
            win_base_reg <= win_base_next;
            tap_base_reg <= tap_base_next;
            im_reg       <= im_next;
            k_reg        <= k_next;
            filt_reg     <= filt_next;
            win_last_reg <= win_last_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign addr_bus.addr_valid = valid_reg;
    assign addr_bus.im_addr    = im_reg;
    assign addr_bus.k_addr     = k_reg;
    assign addr_bus.filt_addr  = filt_reg;
    assign addr_bus.win_last   = win_last_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
endmodule
